// File: rtl/mac_pkg.sv
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared types and default sizes for the MAC lane and its feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_VEC_LEN    = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_operand_sequencer_if.sv
// ============================================================================
// Module   : mac_operand_sequencer_if
// Purpose  : Control, FIFO-pop and MAC-drive signals of one operand sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_operand_sequencer_if
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH
) ();

    logic                  start;
    logic                  abort;
    logic                  a_empty;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_rd_en;
    logic                  b_empty;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_rd_en;
    logic                  mac_en;
    logic                  mac_clr;
    logic [DATA_WIDTH-1:0] mac_ain;
    logic [DATA_WIDTH-1:0] mac_bin;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, abort, a_empty, a_data, b_empty, b_data,
        output a_rd_en, b_rd_en, mac_en, mac_clr, mac_ain, mac_bin, busy, done
    );

    modport slave (
        output start, abort, a_empty, a_data, b_empty, b_data,
        input  a_rd_en, b_rd_en, mac_en, mac_clr, mac_ain, mac_bin, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/mac_operand_sequencer.sv
// ============================================================================
// Module   : mac_operand_sequencer
// Purpose  : Pops VEC_LEN operand pairs into one MAC lane, adds the drain beat
//            and flags done once the accumulator holds the dot product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int VEC_LEN    = c_DEF_VEC_LEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mac_operand_sequencer_if.master   bus
);

    localparam int                 c_CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(VEC_LEN - 1);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_mac_en;
    logic                  r_mac_clr;
    logic [DATA_WIDTH-1:0] r_mac_ain;
    logic [DATA_WIDTH-1:0] r_mac_bin;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_start_ok;
    logic                  w_abort_ok;
    logic                  w_pop;
    logic                  w_last_pop;

    // busy is registered so the post-abort clear cycle and the done cycle
    // still read as busy even though the FSM is already back in IDLE.
    always_comb begin
        w_start_ok = (r_state == IDLE) && !r_busy && bus.start;
        w_abort_ok = (r_state != IDLE) && bus.abort;
        w_pop      = rst_n && ((r_state == CLEAR) || (r_state == FEED)) &&
                     !bus.abort && !bus.a_empty && !bus.b_empty;
        w_last_pop = w_pop && (r_count == c_LAST);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_state_next = CLEAR;
            end
            CLEAR, FEED: begin
                if (w_abort_ok)      w_state_next = IDLE;
                else if (w_last_pop) w_state_next = DRAIN;
                else                 w_state_next = FEED;
            end
            DRAIN: begin
                w_state_next = w_abort_ok ? IDLE : DONE;
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                r_count <= '0;
            end else if (w_pop) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // DRAIN loads the zero beat that flushes the MAC's product register;
    // DONE then raises done for the cycle in which Cout is final.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_mac_ain <= '0;
            r_mac_bin <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_mac_clr <= w_start_ok || w_abort_ok;
            r_mac_en  <= w_pop || ((r_state == DRAIN) && !w_abort_ok);
            if (w_pop) begin
                r_mac_ain <= bus.a_data;
                r_mac_bin <= bus.b_data;
            end else if (r_state == DRAIN) begin
                r_mac_ain <= '0;
                r_mac_bin <= '0;
            end
            r_done <= (r_state == DONE) && !w_abort_ok;
            r_busy <= (w_state_next != IDLE) || (r_state == DONE) || w_abort_ok;
        end
    end

    assign bus.a_rd_en = w_pop;
    assign bus.b_rd_en = w_pop;
    assign bus.mac_en  = r_mac_en;
    assign bus.mac_clr = r_mac_clr;
    assign bus.mac_ain = r_mac_ain;
    assign bus.mac_bin = r_mac_bin;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
// ============================================================================
// Module   : tb_mac_operand_sequencer
// Purpose  : Drives the sequencer from show-ahead FIFO models into a MAC model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_operand_sequencer;
    import mac_pkg::*;

    localparam int DW = c_DEF_DATA_WIDTH;
    localparam int VL = c_DEF_VEC_LEN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.DATA_WIDTH(DW)) bus ();
    mac_operand_sequencer_if #(.DATA_WIDTH(DW)) bus1 ();

    mac_operand_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mac_operand_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0]   q_a[$];
    logic [DW-1:0]   q_b[$];
    logic [3*DW-1:0] m_acc  = '0;
    logic [3*DW-1:0] m_prod = '0;
    logic [DW-1:0]   last_ain = '0;
    logic [DW-1:0]   last_bin = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MAC with an internal product register: each enabled beat accumulates the previous product.
    task automatic mac_step(input logic rv, input logic clr, input logic en,
                            input logic [DW-1:0] ain, input logic [DW-1:0] bin,
                            inout logic [3*DW-1:0] acc, inout logic [3*DW-1:0] prod);
        if (!rv || clr) begin
            acc  = '0;
            prod = '0;
        end else if (en) begin
            acc  = acc + prod;
            prod = (3*DW)'(ain) * (3*DW)'(bin);
        end
    endtask

    // data_mode: 0 k/2, 1 all 255, 2 random. stall_mode: 0 none, 1 B gap after 4th pop, 2 random.
    task automatic run_dot(input int data_mode, input int stall_mode, input int abort_after,
                           input int rst_after, input bit spurious);
        logic [DW-1:0] ea[$];
        logic [DW-1:0] eb[$];
        int unsigned expsum = 0;
        bit fin = 0;
        bit prev_pop = 0;
        bit pop_now;
        bit a_st, b_st, exp_pop, exp_en, exp_busy, exp_done, exp_clr;
        int x = -1, r = -1, plast = -1, pops = 0, ebeat = 0, beats = 0, dones = 0, stall_cnt = 0;
        q_a.delete();
        q_b.delete();
        for (int k = 0; k < VL; k++) begin
            logic [DW-1:0] av, bv;
            case (data_mode)
                0:       begin av = DW'(k + 1); bv = DW'(2);   end
                1:       begin av = DW'(255);   bv = DW'(255); end
                default: begin av = DW'($urandom); bv = DW'($urandom); end
            endcase
            q_a.push_back(av); q_b.push_back(bv);
            ea.push_back(av);  eb.push_back(bv);
            expsum += int'(av) * int'(bv);
        end
        for (int t = 0; t < 400 && !fin; t++) begin
            a_st = 0; b_st = 0;
            if (stall_mode == 1 && pops == 4 && stall_cnt < 3) begin
                b_st = 1; stall_cnt++;
            end else if (stall_mode == 2) begin
                a_st = ($urandom_range(0, 3) == 0);
                b_st = ($urandom_range(0, 3) == 0);
            end
            bus.start = (t == 0) || (spurious && ((pops == 2) ||
                        (plast >= 0 && pops == VL && t == plast + 3)));
            bus.abort = 1'b0;
            if (abort_after >= 0 && x < 0 && pops == abort_after) begin bus.abort = 1'b1; x = t; end
            rst_n = 1'b1;
            if (rst_after >= 0 && r < 0 && pops == rst_after) begin rst_n = 1'b0; r = t; end
            bus.a_empty = a_st || (q_a.size() == 0);
            bus.b_empty = b_st || (q_b.size() == 0);
            bus.a_data  = (q_a.size() != 0) ? q_a[0] : '0;
            bus.b_data  = (q_b.size() != 0) ? q_b[0] : '0;
            #1;
            exp_pop  = rst_n && !bus.abort && !bus.a_empty && !bus.b_empty && t >= 1 &&
                       pops < VL && x < 0 && r < 0;
            exp_en   = prev_pop || (x < 0 && r < 0 && pops == VL && t == plast + 2);
            exp_done = (x < 0 && r < 0 && pops == VL && t == plast + 3);
            exp_clr  = (t == 1) || (x >= 0 && t == x + 1);
            exp_busy = (t >= 1) && !(x >= 0 && t > x + 1) && !(r >= 0 && t > r) &&
                       !(pops == VL && plast >= 0 && t > plast + 3);
            if (exp_en) begin
                last_ain = (ebeat < VL) ? ea[ebeat] : '0;
                last_bin = (ebeat < VL) ? eb[ebeat] : '0;
                ebeat++;
            end
            chk("a_rd_en", bus.a_rd_en, exp_pop);
            chk("b_rd_en", bus.b_rd_en, exp_pop);
            chk("mac_en", bus.mac_en, exp_en);
            chk("mac_clr", bus.mac_clr, exp_clr);
            chk("mac_ain", bus.mac_ain, last_ain);
            chk("mac_bin", bus.mac_bin, last_bin);
            chk("busy", bus.busy, exp_busy);
            chk("done", bus.done, exp_done);
            if (bus.mac_en) beats++;
            if (bus.done) begin
                dones++;
                chk("cout_at_done", m_acc, expsum);
            end
            mac_step(rst_n, bus.mac_clr, bus.mac_en, bus.mac_ain, bus.mac_bin, m_acc, m_prod);
            pop_now = bus.a_rd_en;
            fin = (x >= 0 && t == x + 3) || (r >= 0 && t == r + 3) ||
                  (x < 0 && r < 0 && pops == VL && t == plast + 5);
            @(posedge clk);
            if (!rst_n) begin last_ain = '0; last_bin = '0; end
            if (pop_now && q_a.size() != 0 && q_b.size() != 0) begin
                void'(q_a.pop_front()); void'(q_b.pop_front());
                pops++; plast = t;
            end
            prev_pop = pop_now;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("run_finished", fin, 1);
        if (abort_after >= 0) begin
            chk("abort_pops", pops, abort_after);
            chk("abort_cout", m_acc, 0);
            chk("abort_a_left", q_a.size(), VL - abort_after);
            chk("abort_no_done", dones, 0);
        end else if (rst_after >= 0) begin
            chk("rst_pops", pops, rst_after);
            chk("rst_no_done", dones, 0);
        end else begin
            chk("beats", beats, VL + 1);
            chk("dones", dones, 1);
            chk("pops", pops, VL);
            chk("final_cout", m_acc, expsum);
        end
    endtask

    initial begin
        logic [3*DW-1:0] acc1 = '0;
        logic [3*DW-1:0] prod1 = '0;
        bus.start = 0; bus.abort = 0;
        bus.a_empty = 0; bus.b_empty = 0; bus.a_data = 8'h5A; bus.b_data = 8'hA5;
        bus1.start = 0; bus1.abort = 0;
        bus1.a_empty = 1; bus1.b_empty = 1; bus1.a_data = '0; bus1.b_data = '0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_en", bus.a_rd_en, 0);
        chk("rst_mac_en", bus.mac_en, 0);
        chk("rst_mac_clr", bus.mac_clr, 0);
        chk("rst_ain", bus.mac_ain, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        bus.a_empty = 1; bus.b_empty = 1;
        rst_n = 1;
        @(posedge clk); @(negedge clk);

        run_dot(0, 0, -1, -1, 0);
        run_dot(0, 1, -1, -1, 0);
        run_dot(1, 0, -1, -1, 0);
        run_dot(2, 0, -1, -1, 1);
        repeat (3) run_dot(2, 2, -1, -1, 0);
        run_dot(0, 0, 3, -1, 0);
        run_dot(2, 0, -1, 3, 0);
        run_dot(0, 0, -1, -1, 0);

        // single-pair build: the pop happens in the clear cycle, done three cycles later
        for (int t = 0; t < 7; t++) begin
            bus1.start   = (t == 0);
            bus1.a_empty = (t != 1);
            bus1.b_empty = (t != 1);
            bus1.a_data  = DW'(7);
            bus1.b_data  = DW'(9);
            #1;
            chk("v1_pop", bus1.a_rd_en, (t == 1));
            chk("v1_clr", bus1.mac_clr, (t == 1));
            chk("v1_en", bus1.mac_en, (t == 2 || t == 3));
            chk("v1_done", bus1.done, (t == 4));
            if (bus1.done) chk("v1_cout", acc1, 63);
            mac_step(rst_n, bus1.mac_clr, bus1.mac_en, bus1.mac_ain, bus1.mac_bin, acc1, prod1);
            @(posedge clk); @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
